float2fixed_pipe: RTL and testbench

//  Multi-lane, pipelined half/custom-float to signed fixed-point converter.

---
 rtl/float2fixed_pipe_if.sv | 31 +++
 rtl/float2fixed_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_float2fixed_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/float2fixed_pipe_if.sv
// Handshake and data bundle for float2fixed_pipe: input beat side, output beat side
// and per-lane status flags, shared by converter and its producer/consumer.
interface float2fixed_pipe_if #(
  parameter int LANES = 1,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int FIX_W = 44
);
  localparam int FW = 1 + EXP_W + MAN_W;

  logic                   in_valid;
  logic                   in_ready;
  logic                   rnd_mode;
  logic [LANES*FW-1:0]    float_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*FIX_W-1:0] fixed_out;
  logic [LANES-1:0]       sat_flag;
  logic [LANES-1:0]       nan_flag;
  logic [LANES-1:0]       inex_flag;

  modport master (
    output in_valid, rnd_mode, float_in, out_ready,
    input  in_ready, out_valid, fixed_out, sat_flag, nan_flag, inex_flag
  );

  modport slave (
    input  in_valid, rnd_mode, float_in, out_ready,
    output in_ready, out_valid, fixed_out, sat_flag, nan_flag, inex_flag
  );
endinterface

// File: rtl/float2fixed_pipe.sv
// Multi-lane three-stage float to signed fixed-point converter: classify, shift/round,
// negate/saturate. One global advance enable stalls every stage together.
module float2fixed_pipe #(
  parameter int LANES  = 1,
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10,
  parameter int FIX_W  = 44,
  parameter int FRAC_W = 24
) (
  input logic               clk,
  input logic               reset,
  float2fixed_pipe_if.slave bus
);
  localparam int FW    = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int MW    = MAN_W + 1;
  localparam int MAG_W = FIX_W + MW + 1;
  localparam int RX_W  = MW + MAN_W + 2;
  localparam int SHW   = $clog2(FIX_W + MAN_W + 4);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [MAG_W-1:0] MAX_MAG  = {{(MAG_W-FIX_W+1){1'b0}}, {(FIX_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] MIN_MAG  = {{(MAG_W-FIX_W){1'b0}}, 1'b1, {(FIX_W-1){1'b0}}};
  localparam logic [FIX_W-1:0] FIX_MAX  = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0] FIX_MIN  = {1'b1, {(FIX_W-1){1'b0}}};

  logic en_s;

  logic             sign_s   [LANES];
  logic [EXP_W-1:0] exp_s    [LANES];
  logic [MAN_W-1:0] frac_s   [LANES];
  logic             nan_s    [LANES];
  logic             inf_s    [LANES];
  logic [MW-1:0]    man_s    [LANES];
  int               e_term_s [LANES];
  logic             left_s   [LANES];
  logic             big_s    [LANES];
  logic [SHW-1:0]   sh_s     [LANES];

  logic             s1_valid_r;
  logic             s1_rnd_r;
  logic             s1_sign_r [LANES];
  logic             s1_nan_r  [LANES];
  logic             s1_inf_r  [LANES];
  logic             s1_left_r [LANES];
  logic             s1_big_r  [LANES];
  logic [MW-1:0]    s1_man_r  [LANES];
  logic [SHW-1:0]   s1_sh_r   [LANES];

  logic [RX_W-1:0]  rx_s   [LANES];
  logic             rup_s  [LANES];
  logic [MAG_W-1:0] mag_s  [LANES];
  logic             ovf_s  [LANES];
  logic             inex_s [LANES];

  logic             s2_valid_r;
  logic             s2_sign_r [LANES];
  logic             s2_nan_r  [LANES];
  logic             s2_ovf_r  [LANES];
  logic             s2_inex_r [LANES];
  logic [MAG_W-1:0] s2_mag_r  [LANES];

  logic [FIX_W-1:0] res_s   [LANES];
  logic             sat_s   [LANES];
  logic             nanf_s  [LANES];
  logic             inexf_s [LANES];

  logic                   out_valid_r;
  logic [LANES*FIX_W-1:0] fixed_r;
  logic [LANES-1:0]       sat_r;
  logic [LANES-1:0]       nan_r;
  logic [LANES-1:0]       inex_r;

  assign en_s          = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.fixed_out = fixed_r;
  assign bus.sat_flag  = sat_r;
  assign bus.nan_flag  = nan_r;
  assign bus.inex_flag = inex_r;

  // Stage 1 logic: unpack, classify, attach hidden bit, derive shift direction and amount.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sign_s[k]   = bus.float_in[k*FW + FW - 1];
      exp_s[k]    = bus.float_in[k*FW + MAN_W +: EXP_W];
      frac_s[k]   = bus.float_in[k*FW +: MAN_W];
      nan_s[k]    = 1'b0;
      inf_s[k]    = 1'b0;
      man_s[k]    = '0;
      e_term_s[k] = 0;
      left_s[k]   = 1'b1;
      big_s[k]    = 1'b0;
      sh_s[k]     = '0;
      if (exp_s[k] == EXP_ONES) begin
        nan_s[k] = (frac_s[k] != '0);
        inf_s[k] = (frac_s[k] == '0);
      end else if (exp_s[k] == '0) begin
        man_s[k]    = {1'b0, frac_s[k]};
        e_term_s[k] = 1 - BIAS - MAN_W + FRAC_W;
      end else begin
        man_s[k]    = {1'b1, frac_s[k]};
        e_term_s[k] = int'(exp_s[k]) - BIAS - MAN_W + FRAC_W;
      end
      // Shifts beyond these limits resolve to "certain overflow" or "flushes to zero".
      if (e_term_s[k] >= 0) begin
        if (e_term_s[k] > FIX_W) begin
          big_s[k] = 1'b1;
        end else begin
          sh_s[k] = SHW'(e_term_s[k]);
        end
      end else begin
        left_s[k] = 1'b0;
        if (-e_term_s[k] > MAN_W + 2) begin
          big_s[k] = 1'b1;
        end else begin
          sh_s[k] = SHW'(-e_term_s[k]);
        end
      end
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_rnd_r   <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_sign_r[k] <= 1'b0;
        s1_nan_r[k]  <= 1'b0;
        s1_inf_r[k]  <= 1'b0;
        s1_left_r[k] <= 1'b0;
        s1_big_r[k]  <= 1'b0;
        s1_man_r[k]  <= '0;
        s1_sh_r[k]   <= '0;
      end
    end else if (en_s) begin
      s1_valid_r <= bus.in_valid;
      s1_rnd_r   <= bus.rnd_mode;
      for (int k = 0; k < LANES; k++) begin
        s1_sign_r[k] <= sign_s[k];
        s1_nan_r[k]  <= nan_s[k];
        s1_inf_r[k]  <= inf_s[k];
        s1_left_r[k] <= left_s[k];
        s1_big_r[k]  <= big_s[k];
        s1_man_r[k]  <= man_s[k];
        s1_sh_r[k]   <= sh_s[k];
      end
    end
  end

  // Stage 2 logic: barrel shift, round (guard/lsb/sticky below the kept bits), inexact detect.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rx_s[k]   = '0;
      rup_s[k]  = 1'b0;
      mag_s[k]  = '0;
      ovf_s[k]  = 1'b0;
      inex_s[k] = 1'b0;
      if (s1_nan_r[k] || s1_inf_r[k]) begin
        ovf_s[k] = s1_inf_r[k];
      end else if (s1_left_r[k]) begin
        if (s1_big_r[k]) begin
          ovf_s[k] = (s1_man_r[k] != '0);
        end else begin
          mag_s[k] = MAG_W'(s1_man_r[k]) << s1_sh_r[k];
        end
      end else if (s1_big_r[k]) begin
        inex_s[k] = (s1_man_r[k] != '0);
      end else begin
        rx_s[k]   = {s1_man_r[k], {(MAN_W+2){1'b0}}} >> s1_sh_r[k];
        inex_s[k] = rx_s[k][MAN_W+1] | (|rx_s[k][MAN_W:0]);
        rup_s[k]  = s1_rnd_r & rx_s[k][MAN_W+1] & (rx_s[k][MAN_W+2] | (|rx_s[k][MAN_W:0]));
        mag_s[k]  = MAG_W'(rx_s[k][RX_W-1:MAN_W+2]) + MAG_W'(rup_s[k]);
      end
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s2_sign_r[k] <= 1'b0;
        s2_nan_r[k]  <= 1'b0;
        s2_ovf_r[k]  <= 1'b0;
        s2_inex_r[k] <= 1'b0;
        s2_mag_r[k]  <= '0;
      end
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      for (int k = 0; k < LANES; k++) begin
        s2_sign_r[k] <= s1_sign_r[k];
        s2_nan_r[k]  <= s1_nan_r[k];
        s2_ovf_r[k]  <= ovf_s[k];
        s2_inex_r[k] <= inex_s[k];
        s2_mag_r[k]  <= mag_s[k];
      end
    end
  end

  // Stage 3 logic: the negative limit is one larger in magnitude, so it is not a clamp.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      res_s[k]   = '0;
      sat_s[k]   = 1'b0;
      nanf_s[k]  = 1'b0;
      inexf_s[k] = 1'b0;
      if (s2_nan_r[k]) begin
        nanf_s[k] = 1'b1;
      end else if (s2_ovf_r[k] || (s2_mag_r[k] > (s2_sign_r[k] ? MIN_MAG : MAX_MAG))) begin
        res_s[k]   = s2_sign_r[k] ? FIX_MIN : FIX_MAX;
        sat_s[k]   = 1'b1;
        inexf_s[k] = s2_inex_r[k];
      end else begin
        res_s[k]   = s2_sign_r[k] ? -s2_mag_r[k][FIX_W-1:0] : s2_mag_r[k][FIX_W-1:0];
        inexf_s[k] = s2_inex_r[k];
      end
    end
  end

  // Output register: updated only on advance, so results hold while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      fixed_r     <= '0;
      sat_r       <= '0;
      nan_r       <= '0;
      inex_r      <= '0;
    end else if (en_s) begin
      out_valid_r <= s2_valid_r;
      for (int k = 0; k < LANES; k++) begin
        fixed_r[k*FIX_W +: FIX_W] <= res_s[k];
        sat_r[k]                  <= sat_s[k];
        nan_r[k]                  <= nanf_s[k];
        inex_r[k]                 <= inexf_s[k];
      end
    end
  end
endmodule

// File: tb/tb_float2fixed_pipe.sv
// Directed bench for float2fixed_pipe: three single-lane configurations share one stimulus
// stream; a four-lane instance runs random beats under a stalling consumer.
`timescale 1ns/1ps
module tb_float2fixed_pipe;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        s_valid = 1'b0;
  logic        s_rnd   = 1'b0;
  logic [15:0] s_f     = 16'h0000;
  logic        s_ordy  = 1'b1;

  logic [63:0]  beats [20];
  logic [46:0]  exp_r;
  logic [175:0] held_fix;
  logic [11:0]  held_flags;
  logic         stalled;
  logic         stale;
  int           sent;
  int           got;
  int           cyc;

  float2fixed_pipe_if #(.LANES(1), .EXP_W(5), .MAN_W(10), .FIX_W(44)) if0 ();
  float2fixed_pipe_if #(.LANES(1), .EXP_W(5), .MAN_W(10), .FIX_W(44)) if3 ();
  float2fixed_pipe_if #(.LANES(1), .EXP_W(5), .MAN_W(10), .FIX_W(32)) if4 ();
  float2fixed_pipe_if #(.LANES(4), .EXP_W(5), .MAN_W(10), .FIX_W(44)) if5 ();

  assign if0.in_valid  = s_valid;
  assign if0.rnd_mode  = s_rnd;
  assign if0.float_in  = s_f;
  assign if0.out_ready = s_ordy;
  assign if3.in_valid  = s_valid;
  assign if3.rnd_mode  = s_rnd;
  assign if3.float_in  = s_f;
  assign if3.out_ready = s_ordy;
  assign if4.in_valid  = s_valid;
  assign if4.rnd_mode  = s_rnd;
  assign if4.float_in  = s_f;
  assign if4.out_ready = s_ordy;

  float2fixed_pipe #(.LANES(1), .EXP_W(5), .MAN_W(10), .FIX_W(44), .FRAC_W(24))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  float2fixed_pipe #(.LANES(1), .EXP_W(5), .MAN_W(10), .FIX_W(44), .FRAC_W(0))
    u3 (.clk(clk), .reset(reset), .bus(if3));
  float2fixed_pipe #(.LANES(1), .EXP_W(5), .MAN_W(10), .FIX_W(32), .FRAC_W(24))
    u4 (.clk(clk), .reset(reset), .bus(if4));
  float2fixed_pipe #(.LANES(4), .EXP_W(5), .MAN_W(10), .FIX_W(44), .FRAC_W(24))
    u5 (.clk(clk), .reset(reset), .bus(if5));

  task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  // Fixed value plus {sat,nan,inex} of one single-lane instance (0, 3 or 4).
  task automatic chk_single(input int sel, input string tag, input logic [43:0] fx, input logic [2:0] fl);
    case (sel)
      0: begin
        check_eq({tag, "_fix"}, if0.fixed_out, fx);
        check_eq({tag, "_flags"}, {if0.sat_flag, if0.nan_flag, if0.inex_flag}, fl);
      end
      3: begin
        check_eq({tag, "_fix"}, if3.fixed_out, fx);
        check_eq({tag, "_flags"}, {if3.sat_flag, if3.nan_flag, if3.inex_flag}, fl);
      end
      default: begin
        check_eq({tag, "_fix"}, if4.fixed_out, fx);
        check_eq({tag, "_flags"}, {if4.sat_flag, if4.nan_flag, if4.inex_flag}, fl);
      end
    endcase
  endtask

  // One beat into the single-lane instances; returns once it is visible on the output.
  task automatic xfer(input logic [15:0] f, input logic rnd);
    @(negedge clk);
    s_valid = 1'b1;
    s_f     = f;
    s_rnd   = rnd;
    check_eq("in_ready", if0.in_ready, 1'b1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    check_eq("lat_edge1", if0.out_valid, 1'b0);
    @(posedge clk);
    #1 check_eq("lat_edge2", if0.out_valid, 1'b0);
    @(posedge clk);
    #1 check_eq("lat_edge3", if0.out_valid, 1'b1);
  endtask

  // Default format: every finite fp16 value is exact at 24 fraction bits and fits 44 bits.
  function automatic logic [46:0] ref_conv(input logic [15:0] f);
    logic [4:0] e;
    logic [9:0] m;
    longint     v;
    e = f[14:10];
    m = f[9:0];
    if (e == 5'h1F) begin
      if (m != 10'd0) ref_conv = {3'b010, 44'd0};
      else if (f[15]) ref_conv = {3'b100, 44'h800_0000_0000};
      else ref_conv = {3'b100, 44'h7FF_FFFF_FFFF};
    end else begin
      if (e == 5'd0) v = longint'(m);
      else v = longint'({1'b1, m}) << (e - 5'd1);
      if (f[15]) v = -v;
      ref_conv = {3'b000, v[43:0]};
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if5.in_valid  = 1'b0;
    if5.rnd_mode  = 1'b0;
    if5.float_in  = '0;
    if5.out_ready = 1'b0;

    #2 reset = 1'b1;
    #1;
    check_eq("rst_valid", if0.out_valid, 1'b0);
    check_eq("rst_fix", if0.fixed_out, 44'd0);
    check_eq("rst_flags", {if0.sat_flag, if0.nan_flag, if0.inex_flag}, 3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 check_eq("rdy_after_rst", if0.in_ready, 1'b1);

    xfer(16'h3C00, 1'b0); chk_single(0, "t1_one",   44'h000_0100_0000, 3'b000);
    xfer(16'hBC00, 1'b0); chk_single(0, "t1_mone",  44'hFFF_FF00_0000, 3'b000);
    xfer(16'h7BFF, 1'b0); chk_single(0, "t1_max",   44'h0FF_E000_0000, 3'b000);
    xfer(16'h0001, 1'b0); chk_single(0, "t1_sub",   44'h000_0000_0001, 3'b000);

    xfer(16'h7C00, 1'b0); chk_single(0, "t2_pinf",  44'h7FF_FFFF_FFFF, 3'b100);
    xfer(16'hFC00, 1'b0); chk_single(0, "t2_ninf",  44'h800_0000_0000, 3'b100);
    xfer(16'h7E00, 1'b0); chk_single(0, "t2_nan",   44'h000_0000_0000, 3'b010);
    xfer(16'h8000, 1'b0); chk_single(0, "t2_nzero", 44'h000_0000_0000, 3'b000);

    xfer(16'h4100, 1'b1); chk_single(3, "t3_rne_2p5",  44'd2,             3'b001);
    xfer(16'h4300, 1'b1); chk_single(3, "t3_rne_3p5",  44'd4,             3'b001);
    xfer(16'hC100, 1'b1); chk_single(3, "t3_rne_m2p5", 44'hFFF_FFFF_FFFE, 3'b001);
    xfer(16'h4100, 1'b0); chk_single(3, "t3_trz_2p5",  44'd2,             3'b001);
    xfer(16'h4300, 1'b0); chk_single(3, "t3_trz_3p5",  44'd3,             3'b001);
    xfer(16'hC100, 1'b0); chk_single(3, "t3_trz_m2p5", 44'hFFF_FFFF_FFFE, 3'b001);

    xfer(16'h7BFF, 1'b0); chk_single(4, "t4_big",  44'h7FFF_FFFF, 3'b100);
    xfer(16'h5800, 1'b0); chk_single(4, "t4_128",  44'h7FFF_FFFF, 3'b100);
    xfer(16'h57FF, 1'b0); chk_single(4, "t4_fits", 44'h7FF0_0000, 3'b000);

    beats[0] = {16'h8000, 16'h7E01, 16'hFC00, 16'h7C00};
    beats[1] = {16'h0001, 16'h3C00, 16'hBC00, 16'h7BFF};
    for (int i = 2; i < 20; i++) begin
      beats[i] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    end
    sent    = 0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    while (got < 20 && cyc < 600) begin
      @(negedge clk);
      if5.out_ready = ($urandom_range(0, 2) != 0);
      if5.in_valid  = (sent < 20);
      if (sent < 20) if5.float_in = beats[sent];
      else if5.float_in = '0;
      #1;
      check_eq("t5_rdy_rule", if5.in_ready, !if5.out_valid || if5.out_ready);
      if (stalled) begin
        check_eq("t5_hold_valid", if5.out_valid, 1'b1);
        check_eq("t5_hold_flags", {if5.sat_flag, if5.nan_flag, if5.inex_flag}, held_flags);
        for (int k = 0; k < 4; k++) begin
          check_eq("t5_hold_fix", if5.fixed_out[k*44 +: 44], held_fix[k*44 +: 44]);
        end
      end
      if (if5.out_valid && if5.out_ready) begin
        for (int k = 0; k < 4; k++) begin
          exp_r = ref_conv(beats[got][k*16 +: 16]);
          check_eq("t5_fix", if5.fixed_out[k*44 +: 44], exp_r[43:0]);
          check_eq("t5_flags", {if5.sat_flag[k], if5.nan_flag[k], if5.inex_flag[k]}, exp_r[46:44]);
        end
        got++;
      end
      stalled    = if5.out_valid && !if5.out_ready;
      held_fix   = if5.fixed_out;
      held_flags = {if5.sat_flag, if5.nan_flag, if5.inex_flag};
      if (if5.in_valid && if5.in_ready) sent++;
      cyc++;
    end
    check_eq("t5_delivered", got, 20);
    check_eq("t5_accepted", sent, 20);
    @(negedge clk);
    if5.in_valid  = 1'b0;
    if5.out_ready = 1'b1;

    @(negedge clk);
    s_valid = 1'b1;
    s_f     = 16'h3C00;
    @(posedge clk);
    #1 s_f = 16'h4000;
    @(posedge clk);
    #1 s_f = 16'h4200;
    @(posedge clk);
    #1 s_valid = 1'b0;
    check_eq("t6_full", if0.out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_valid", if0.out_valid, 1'b0);
    check_eq("t6_async_fix", if0.fixed_out, 44'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    stale = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 if (if0.out_valid) stale = 1'b1;
    end
    check_eq("t6_no_stale", stale, 1'b0);
    xfer(16'hBC00, 1'b0); chk_single(0, "t6_next", 44'hFFF_FF00_0000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
